// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised RAM serving the CPU data-memory read/write port.
// Latency: dm_ready pulses in the cycle after edge N+WAIT_CYCLES for a request sampled at edge N.
// Backpressure: none; one access in flight, requests seen outside IDLE are ignored.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] read_address_to_dm,
  input  logic [31:0] write_address_to_dm,
  input  logic [31:0] data_to_dm,
  output logic [31:0] data_from_dm,
  output logic        dm_ready,
  output logic        dm_error
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Captured request: type, selected byte address and write data
  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] dat;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        dm_ready_q, dm_ready_d;
  logic        dm_error_q, dm_error_d;
  logic [31:0] data_from_dm_q, data_from_dm_d;

  // Contents deliberately survive reset
  logic [31:0] mem [DEPTH_WORDS];

  req_t          in_req;
  req_t          acc_req;
  logic          acc_legal;
  logic [AW-1:0] acc_idx;
  logic          go_resp;
  logic          mem_we;

  // Incoming request (write wins over read) and the request the access is performed for.
  // With zero wait states the access happens on the sampling edge, so it uses the live inputs.
  always_comb begin
    in_req.is_wr = dm_write;
    in_req.addr  = dm_write ? write_address_to_dm : read_address_to_dm;
    in_req.dat   = data_to_dm;
    acc_req      = (state_q == IDLE) ? in_req : req_q;
    acc_legal    = (acc_req.addr[1:0] == 2'b00) && ((acc_req.addr >> (AW + 2)) == 32'd0);
    acc_idx      = acc_req.addr[AW+1:2];
  end

  // Next-state, wait counter and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_write || dm_read) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          go_resp = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    dm_ready_d     = go_resp;
    dm_error_d     = go_resp && !acc_legal;
    data_from_dm_d = data_from_dm_q;
    if (go_resp && !acc_req.is_wr) begin
      data_from_dm_d = acc_legal ? mem[acc_idx] : 32'd0;
    end
    // A pending access is discarded if reset coincides with its commit edge
    mem_we = go_resp && acc_req.is_wr && acc_legal && !reset;
  end

  // FSM state, captured request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      req_q          <= '0;
      dm_ready_q     <= 1'b0;
      dm_error_q     <= 1'b0;
      data_from_dm_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      dm_ready_q     <= dm_ready_d;
      dm_error_q     <= dm_error_d;
      data_from_dm_q <= data_from_dm_d;
    end
  end

  // RAM write port, committed on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_req.dat;
    end
  end

  assign data_from_dm = data_from_dm_q;
  assign dm_ready     = dm_ready_q;
  assign dm_error     = dm_error_q;

endmodule
